// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative signed MULT/DIV.
// Results are registered and held until the next operation completes.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             ovf,
   output logic             busy,
   output logic             done,
   output logic             dbz
);
   localparam int              SW      = $clog2(WIDTH);
   localparam logic [SW-1:0]   LAST    = SW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
   typedef enum logic [3:0] {
      OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3, OP_SLL = 4'd4,
      OP_SRL = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7, OP_SLTU = 4'd8, OP_SRA = 4'd9,
      OP_MULT = 4'd10, OP_DIV = 4'd11, OP_NOR = 4'd12
   } op_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic             div_ovf_q, div_ovf_d;
   logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;

   op_t              op;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] sum, diff, mag0, mag1, alu_res;
   logic             alu_ovf, alu_legal, is_muldiv, div_by_zero;
   logic [WIDTH:0]   mul_sum, rem_sh, trial, acc_hi_nx;
   logic [WIDTH-1:0] acc_lo_nx, quo, rem, fin_lo, fin_hi;
   logic [2*WIDTH-1:0] prod;

   assign op          = op_t'(ctrl);
   assign shamt       = in1[SW-1:0];
   assign sum         = in0 + in1;
   assign diff        = in0 - in1;
   assign mag0        = in0[WIDTH-1] ? -in0 : in0;
   assign mag1        = in1[WIDTH-1] ? -in1 : in1;
   assign is_muldiv   = (op == OP_MULT) || (op == OP_DIV);
   assign div_by_zero = (op == OP_DIV) && (in1 == '0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      alu_res   = '0;
      alu_ovf   = 1'b0;
      alu_legal = 1'b1;
      case (op)
         OP_AND:  alu_res = in0 & in1;
         OP_OR:   alu_res = in0 | in1;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
         end
         OP_XOR:  alu_res = in0 ^ in1;
         OP_SLL:  alu_res = in0 << shamt;
         OP_SRL:  alu_res = in0 >> shamt;
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]);
         end
         OP_SLT:  alu_res = WIDTH'($signed(in0) < $signed(in1));
         OP_SLTU: alu_res = WIDTH'(in0 < in1);
         OP_SRA:  alu_res = $unsigned($signed(in0) >>> shamt);
         OP_NOR:  alu_res = ~(in0 | in1);
         default: alu_legal = 1'b0;
      endcase
   end

   // One iteration step: shift-add for MULT, restoring subtract for DIV, on magnitudes.
   always_comb begin
      mul_sum = acc_hi_q + (acc_lo_q[0] ? {1'b0, dvsr_q} : '0);
      rem_sh  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
      trial   = rem_sh - {1'b0, dvsr_q};
      if (is_div_q) begin
         acc_hi_nx = trial[WIDTH] ? rem_sh : trial;
         acc_lo_nx = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
      end else begin
         acc_hi_nx = {1'b0, mul_sum[WIDTH:1]};
         acc_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
      prod = {acc_hi_nx[WIDTH-1:0], acc_lo_nx};
      quo  = neg_lo_q ? -acc_lo_nx : acc_lo_nx;
      rem  = neg_hi_q ? -acc_hi_nx[WIDTH-1:0] : acc_hi_nx[WIDTH-1:0];
      if (is_div_q) {fin_hi, fin_lo} = {rem, quo};
      else          {fin_hi, fin_lo} = neg_lo_q ? -prod : prod;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (is_muldiv && !div_by_zero) ? S_ITER : S_DONE;
         S_ITER:  if (cnt_q == LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      dvsr_d    = dvsr_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      div_ovf_d = div_ovf_q;
      result_d  = result_q;
      hi_d      = hi_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;
      case (state_q)
         S_IDLE: if (start) begin
            if (is_muldiv && !div_by_zero) begin
               acc_hi_d  = '0;
               acc_lo_d  = (op == OP_DIV) ? mag0 : mag1;
               dvsr_d    = (op == OP_DIV) ? mag1 : mag0;
               cnt_d     = '0;
               is_div_d  = (op == OP_DIV);
               neg_lo_d  = in0[WIDTH-1] ^ in1[WIDTH-1];
               neg_hi_d  = in0[WIDTH-1];
               div_ovf_d = (op == OP_DIV) && (in0 == MIN_VAL) && (&in1);
            end else if (div_by_zero) begin
               result_d = '1;
               hi_d     = in0;
               zero_d   = 1'b0;
               ovf_d    = 1'b0;
               dbz_d    = 1'b1;
            end else begin
               result_d = alu_res;
               hi_d     = '0;
               zero_d   = alu_legal && (alu_res == '0);
               ovf_d    = alu_ovf;
               dbz_d    = 1'b0;
            end
         end
         S_ITER: begin
            acc_hi_d = acc_hi_nx;
            acc_lo_d = acc_lo_nx;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               result_d = fin_lo;
               hi_d     = fin_hi;
               zero_d   = (fin_lo == '0);
               ovf_d    = div_ovf_q;
               dbz_d    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         dvsr_q    <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         div_ovf_q <= 1'b0;
         result_q  <= '0;
         hi_q      <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         state_q   <= state_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         dvsr_q    <= dvsr_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_lo_q  <= neg_lo_d;
         neg_hi_q  <= neg_hi_d;
         div_ovf_q <= div_ovf_d;
         result_q  <= result_d;
         hi_q      <= hi_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
      end
   end

   always_comb begin
      busy   = (state_q == S_ITER);
      done   = (state_q == S_DONE);
      result = result_q;
      hi     = hi_q;
      zero   = zero_q;
      ovf    = ovf_q;
      dbz    = dbz_q;
   end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results, monitor pops on done.
module tb_seq_alu;
   localparam int W = 32;
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   ctrl = '0;
   logic [W-1:0] in0 = '0, in1 = '0;
   logic [W-1:0] result, hi;
   logic         zero, ovf, busy, done, dbz;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .in0(in0), .in1(in1),
      .result(result), .hi(hi), .zero(zero), .ovf(ovf), .busy(busy), .done(done), .dbz(dbz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] result;
      logic [W-1:0] hi;
      logic         zero, ovf, dbz;
      int           lat;
      int           busy_cycles;
      int           issue;
   } exp_t;

   exp_t sb_q[$];
   exp_t held;
   int   n_vec = 0, n_fail = 0;
   int   cyc = 0;
   int   busy_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic exp_t zero_exp();
      exp_t e;
      e.result = '0; e.hi = '0; e.zero = 1'b0; e.ovf = 1'b0; e.dbz = 1'b0;
      e.lat = 1; e.busy_cycles = 0; e.issue = 0;
      return e;
   endfunction

   // Reference model computed with 64-bit signed integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e = zero_exp();
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint smax = (longint'(1) <<< (W-1)) - 1;
      longint smin = -(longint'(1) <<< (W-1));
      longint t;
      logic [63:0] p;
      int sh = int'(b[4:0]);
      case (op)
         4'd0:  e.result = a & b;
         4'd1:  e.result = a | b;
         4'd2:  begin t = sa + sb; e.result = W'(t); e.ovf = (t > smax) || (t < smin); end
         4'd3:  e.result = a ^ b;
         4'd4:  e.result = a << sh;
         4'd5:  e.result = a >> sh;
         4'd6:  begin t = sa - sb; e.result = W'(t); e.ovf = (t > smax) || (t < smin); end
         4'd7:  e.result = (sa < sb) ? 1 : 0;
         4'd8:  e.result = (a < b) ? 1 : 0;
         4'd9:  begin t = sa >>> sh; e.result = W'(t); end
         4'd10: begin
            p = sa * sb;
            e.result = p[W-1:0]; e.hi = p[2*W-1:W];
            e.lat = W + 1; e.busy_cycles = W;
         end
         4'd11: begin
            if (b == '0) begin
               e.result = '1; e.hi = a; e.dbz = 1'b1;
            end else begin
               e.lat = W + 1; e.busy_cycles = W;
               if (a == MINV && b == '1) begin
                  e.result = MINV; e.hi = '0; e.ovf = 1'b1;
               end else begin
                  e.result = W'(sa / sb); e.hi = W'(sa % sb);
               end
            end
         end
         4'd12: e.result = ~(a | b);
         default: ;
      endcase
      e.zero = (op <= 4'd12) && (e.result == '0);
      return e;
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         busy_run = 0;
         held = zero_exp();
      end else begin
         if (busy) begin
            busy_run++;
            check("hold", {result, hi, zero, ovf, dbz},
                  {held.result, held.hi, held.zero, held.ovf, held.dbz});
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               check("result", result, e.result);
               check("hi", hi, e.hi);
               check("zero", zero, e.zero);
               check("ovf", ovf, e.ovf);
               check("dbz", dbz, e.dbz);
               check("latency", cyc - e.issue, e.lat);
               check("busy_cycles", busy_run, e.busy_cycles);
               held = e;
            end
            busy_run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_result"}, result, '0);
      check({tag, "_hi"}, hi, '0);
      check({tag, "_zero"}, zero, 1'b0);
      check({tag, "_ovf"}, ovf, 1'b0);
      check({tag, "_dbz"}, dbz, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
   endtask

   // Called with the DUT idle, just after an edge; returns the same way.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise);
      exp_t e = model(op, a, b);
      bit   got = 1'b0;
      e.issue = cyc;
      sb_q.push_back(e);
      start = 1'b1; ctrl = op; in0 = a; in1 = b;
      tick();
      for (int i = 0; i < W + 4; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            ctrl = 4'($urandom_range(0, 15)); in0 = $urandom; in1 = $urandom;
         end
         tick();
      end
      if (!got) begin
         n_vec++; n_fail++;
         $display("FAIL timeout: got no done expected done within %0d cycles (op %0d)", W + 4, op);
         void'(sb_q.pop_back());
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return MINV;
         3:       return MAXV;
         4:       return W'($urandom_range(0, 10));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (3) tick();
      check_reset_outputs("por");
      rst_n = 1'b1;

      run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
      run_op(4'd6, 32'd5, 32'd5, 1'b0);
      run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op(4'd9, 32'h8000_0000, 32'd4, 1'b0);
      run_op(4'd10, -32'sd3, 32'd7, 1'b1);
      run_op(4'd11, -32'sd7, 32'd2, 1'b1);
      run_op(4'd11, 32'd9, 32'd0, 1'b1);
      run_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(4'd13, 32'd1, 32'd2, 1'b0);
      run_op(4'd4, 32'd1, 32'hFFFF_FFE5, 1'b0);

      // Abort a MULT partway through its iterations.
      start = 1'b1; ctrl = 4'd10; in0 = -32'sd3; in1 = 32'd7;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("mid_reset");
      tick();
      rst_n = 1'b1;
      run_op(4'd2, 32'd2, 32'd3, 1'b0);

      for (int i = 0; i < 400; i++)
         run_op(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), 1'b1);

      repeat (3) tick();
      check("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog");
   end
endmodule
